// File: rtl/thumb_fetch_queue_pkg.sv
// Shared definitions for the Thumb fetch front end: T32 prefix decode and halfword move counts.
// Decode imports the same is_t32() so both sides agree on instruction length.
package thumb_fetch_queue_pkg;

    localparam logic [4:0] T32_PFX_A = 5'b11101;
    localparam logic [4:0] T32_PFX_B = 5'b11110;
    localparam logic [4:0] T32_PFX_C = 5'b11111;

    typedef enum logic [1:0] {
        HW_NONE = 2'd0,
        HW_ONE  = 2'd1,
        HW_TWO  = 2'd2
    } hw_cnt_e;

    function automatic logic is_t32(input logic [15:0] hw);
        return (hw[15:11] == T32_PFX_A) || (hw[15:11] == T32_PFX_B) ||
               (hw[15:11] == T32_PFX_C);
    endfunction

endpackage

// File: rtl/thumb_fetch_queue_hw_queue.sv
// Halfword ring buffer: push 0/1/2 and pop 0/1/2 per cycle, flush clears pointers and count.
// The two oldest entries are always visible so a 32-bit instruction can be assembled combinationally.
module thumb_fetch_queue_hw_queue
    import thumb_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  hw_cnt_e                    push_n,
    input  logic [15:0]                push_hw0,
    input  logic [15:0]                push_hw1,
    input  hw_cnt_e                    pop_n,
    output logic [$clog2(DEPTH):0]     count,
    output logic [15:0]                hw0,
    output logic [15:0]                hw1
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [15:0]   mem_q [DEPTH];
    logic [15:0]   mem_d [DEPTH];
    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW:0]   cnt_sum;

    always_comb begin
        mem_d   = mem_q;
        cnt_sum = {1'b0, cnt_q} + (CW+1)'(push_n) - (CW+1)'(pop_n);
        cnt_d   = cnt_sum[CW-1:0];
        wr_d    = wr_q + AW'(push_n);
        rd_d    = rd_q + AW'(pop_n);
        if (push_n != HW_NONE) begin
            mem_d[wr_q] = push_hw0;
        end
        if (push_n == HW_TWO) begin
            mem_d[wr_q + AW'(1)] = push_hw1;
        end
        if (flush) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;
    assign hw0   = mem_q[rd_q];
    assign hw1   = mem_q[rd_q + AW'(1)];

    // Credit accounting upstream must make this impossible.
    no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
                                  cnt_sum <= (CW+1)'(DEPTH));

endmodule

// File: rtl/thumb_fetch_queue.sv
// Decoupled Thumb/Thumb-2 fetch: credit-limited imem requests, halfword queue, 16/32-bit assembly.
// Redirects flush the queue and drop responses already in flight.
module thumb_fetch_queue
    import thumb_fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 8,
    parameter int          MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_is32
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int NW = CW + 4;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   head_pc_q, head_pc_d;
    logic [2:0]    out_q, out_d;
    logic [2:0]    disc_q, disc_d;
    logic          skip_lo_q, skip_lo_d;

    logic [CW-1:0] q_count;
    logic [15:0]   q_hw0, q_hw1;
    logic [15:0]   push_hw0, push_hw1;
    hw_cnt_e       push_n, pop_n;
    logic          flush;

    logic          hw0_is32;
    logic [NW-1:0] need;
    logic          credit_ok;
    logic          req_fire;
    logic          consume;

    thumb_fetch_queue_hw_queue #(.DEPTH(DEPTH)) u_hw_queue (
        .clk      (clk),
        .rst_n    (rst),
        .flush    (flush),
        .push_n   (push_n),
        .push_hw0 (push_hw0),
        .push_hw1 (push_hw1),
        .pop_n    (pop_n),
        .count    (q_count),
        .hw0      (q_hw0),
        .hw1      (q_hw1)
    );

    assign hw0_is32    = is_t32(q_hw0);
    assign instr_valid = hw0_is32 ? (q_count >= CW'(2)) : (q_count >= CW'(1));
    assign instr       = !instr_valid ? 32'h0 :
                         hw0_is32     ? {q_hw1, q_hw0} : {16'h0, q_hw0};
    assign instr_is32  = (q_count != '0) && hw0_is32;
    assign instr_pc    = head_pc_q;

    // Every outstanding word reserves two slots, so responses always fit.
    assign need      = NW'(q_count) + NW'({out_q, 1'b0}) + NW'(2);
    assign credit_ok = (out_q < 3'(MAX_OUT)) && (need <= NW'(DEPTH));

    assign imem_req_valid = rst && !redirect_valid && credit_ok;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign consume        = instr_valid && instr_ready;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_pc_d  = head_pc_q;
        disc_d     = disc_q;
        skip_lo_d  = skip_lo_q;
        flush      = 1'b0;
        push_n     = HW_NONE;
        pop_n      = HW_NONE;
        push_hw0   = skip_lo_q ? imem_rsp_data[31:16] : imem_rsp_data[15:0];
        push_hw1   = imem_rsp_data[31:16];
        out_d      = out_q + 3'(req_fire) - 3'(imem_rsp_valid);

        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        if (redirect_valid) begin
            flush      = 1'b1;
            head_pc_d  = redirect_pc & ~32'd1;
            fetch_pc_d = redirect_pc & ~32'd3;
            skip_lo_d  = redirect_pc[1];
            disc_d     = out_d;
        end else begin
            if (imem_rsp_valid) begin
                if (disc_q != '0) begin
                    disc_d = disc_q - 3'd1;
                end else begin
                    push_n    = skip_lo_q ? HW_ONE : HW_TWO;
                    skip_lo_d = 1'b0;
                end
            end
            if (consume) begin
                pop_n     = hw0_is32 ? HW_TWO : HW_ONE;
                head_pc_d = head_pc_q + (hw0_is32 ? 32'd4 : 32'd2);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            head_pc_q  <= RESET_PC;
            out_q      <= '0;
            disc_q     <= '0;
            skip_lo_q  <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_pc_q  <= head_pc_d;
            out_q      <= out_d;
            disc_q     <= disc_d;
            skip_lo_q  <= skip_lo_d;
        end
    end

endmodule
